// File: rtl/pc_gen_pkg.sv
// Shared fetch-side definitions: PC generator state encoding, boot/exception
// vectors and the MIPS opcode/rt field values used by the branch decode.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        PCG_BOOT    = 2'd0,
        PCG_RUN     = 2'd1,
        PCG_WAIT_DS = 2'd2
    } pcg_state_e;

    localparam logic [31:0] PCG_RESET_PC      = 32'hBFC0_0000;
    localparam logic [31:0] PCG_EXC_VEC_BEV   = 32'hBFC0_0380;
    localparam logic [31:0] PCG_EXC_VEC_NORM  = 32'h8000_0180;
    localparam logic [31:0] PCG_INST_BYTES    = 32'd4;
    localparam int unsigned PCG_BOOT_CNT_W    = 4;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    // Sequential fetch successor; wraps naturally at the top of the 32-bit space.
    function automatic logic [31:0] pcg_seq_next(input logic [31:0] pc);
        return pc + PCG_INST_BYTES;
    endfunction

endpackage

// File: rtl/pc_gen.sv
// Fetch-side PC generator: turns EX branch resolution and commit redirects into
// the I-side request stream, holding redirects until the delay slot is fetched.
// Optional macro PC_ADDR_ERR_EN adds the addr_err output for misaligned PCs.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// PCG_BOOT    | post-reset quiet period, no fetch requests
// PCG_RUN     | normal fetch, pc advances by 4 on each accept
// PCG_WAIT_DS | branch resolved before its delay slot was fetched; hold
//             | the target until the slot at the current pc is accepted
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = PCG_RESET_PC,
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        branch_taken,
    input  logic [31:0] pc_branch_target,
    input  logic        ds_in_pipe,
    input  logic        exc_flush,
    input  logic [31:0] exc_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    output logic        if_kill,
    output logic        fetch_busy
`ifdef PC_ADDR_ERR_EN
    ,
    output logic        addr_err
`endif
);

    localparam logic [PCG_BOOT_CNT_W-1:0] BOOT_LAST = PCG_BOOT_CNT_W'(BOOT_CYCLES - 1);

    pcg_state_e                 state_q, state_d;
    logic [31:0]                pc_q, pc_d;
    logic [31:0]                pend_tgt_q, pend_tgt_d;
    logic [PCG_BOOT_CNT_W-1:0]  boot_cnt_q, boot_cnt_d;
    logic                       req_en;
    logic                       accept;

`ifdef PC_ADDR_ERR_EN
    logic addr_err_q, addr_err_d;

    // A misaligned pc stays flagged until a commit redirect replaces it.
    always_comb begin
        addr_err_d = addr_err_q | (pc_d[1:0] != 2'b00);
        if (exc_flush) begin
            addr_err_d = (exc_target[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign addr_err  = addr_err_q;
    assign req_en    = (state_q != PCG_BOOT) & ~addr_err_q;
    assign inst_addr = pc_q;
`else
    assign req_en    = (state_q != PCG_BOOT);
    assign inst_addr = {pc_q[31:2], 2'b00};
`endif

    assign inst_req   = req_en;
    assign accept     = req_en & inst_addr_ok;
    assign fetch_busy = (state_q == PCG_WAIT_DS);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        boot_cnt_d = boot_cnt_q;
        if_kill    = 1'b0;

        if (exc_flush) begin
            pc_d       = exc_target;
            state_d    = PCG_RUN;
            pend_tgt_d = '0;
            if_kill    = 1'b1;
        end else begin
            unique case (state_q)
                PCG_BOOT: begin
                    if (boot_cnt_q == BOOT_LAST) begin
                        state_d = PCG_RUN;
                    end else begin
                        boot_cnt_d = boot_cnt_q + 1'b1;
                    end
                end
                PCG_RUN: begin
                    if (branch_taken) begin
                        if (ds_in_pipe) begin
                            // Slot already fetched: current pc is past the slot.
                            pc_d    = pc_branch_target;
                            if_kill = 1'b1;
                        end else if (accept) begin
                            pc_d = pc_branch_target;
                        end else begin
                            pend_tgt_d = pc_branch_target;
                            state_d    = PCG_WAIT_DS;
                        end
                    end else if (accept) begin
                        pc_d = pcg_seq_next(pc_q);
                    end
                end
                PCG_WAIT_DS: begin
                    // A second branch here sits in a delay slot and is ignored.
                    if (accept) begin
                        pc_d       = pend_tgt_q;
                        pend_tgt_d = '0;
                        state_d    = PCG_RUN;
                    end
                end
                default: begin
                    state_d = PCG_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= PCG_BOOT;
            pc_q       <= RESET_PC;
            pend_tgt_q <= '0;
            boot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a behavioural fetch model queues expected
// per-cycle outputs and accepted fetch addresses; a monitor pops and compares.
module tb_pc_gen;

    localparam logic [31:0] BOOT_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        branch_taken;
    logic [31:0] pc_branch_target;
    logic        ds_in_pipe;
    logic        exc_flush;
    logic [31:0] exc_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        if_kill;
    logic        fetch_busy;
`ifdef PC_ADDR_ERR_EN
    logic        addr_err;
`endif

    always #5 clk = ~clk;

    pc_gen dut (
        .clk              (clk),
        .resetn           (resetn),
        .branch_taken     (branch_taken),
        .pc_branch_target (pc_branch_target),
        .ds_in_pipe       (ds_in_pipe),
        .exc_flush        (exc_flush),
        .exc_target       (exc_target),
        .inst_req         (inst_req),
        .inst_addr        (inst_addr),
        .inst_addr_ok     (inst_addr_ok),
        .if_kill          (if_kill),
        .fetch_busy       (fetch_busy)
`ifdef PC_ADDR_ERR_EN
        ,
        .addr_err         (addr_err)
`endif
    );

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        kill;
        logic        busy;
    } exp_t;

    exp_t        cyc_q[$];
    logic [31:0] fetch_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Behavioural model: current pc, remaining quiet cycles, optional held redirect.
    logic [31:0] m_pc;
    logic [31:0] m_ptgt;
    int          m_boot;
    bit          m_pend;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic br, input logic [31:0] tgt, input logic ds,
                         input logic exc, input logic [31:0] etgt, input logic ok);
        exp_t e;
        bit   req, acc;
        @(negedge clk);
        branch_taken     = br;
        pc_branch_target = tgt;
        ds_in_pipe       = ds;
        exc_flush        = exc;
        exc_target       = etgt;
        inst_addr_ok     = ok;
        req    = (m_boot == 0);
        acc    = req && ok;
        e.req  = req;
        e.addr = m_pc & 32'hFFFF_FFFC;
        e.kill = exc || (req && !m_pend && br && ds);
        e.busy = m_pend;
        cyc_q.push_back(e);
        if (acc) fetch_q.push_back(m_pc & 32'hFFFF_FFFC);
        if (exc) begin
            m_pc = etgt; m_boot = 0; m_pend = 0;
        end else if (m_boot > 0) begin
            m_boot--;
        end else if (m_pend) begin
            if (acc) begin m_pc = m_ptgt; m_pend = 0; end
        end else if (br) begin
            if (ds || acc) m_pc = tgt;
            else begin m_ptgt = tgt; m_pend = 1; end
        end else if (acc) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic idle_inputs();
        branch_taken = 0; pc_branch_target = '0; ds_in_pipe = 0;
        exc_flush = 0; exc_target = '0; inst_addr_ok = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        resetn = 1'b0;
        idle_inputs();
        #1;
        chk("rst_inst_req", {31'd0, inst_req}, 32'd0);
        chk("rst_inst_addr", inst_addr, BOOT_PC);
        chk("rst_if_kill", {31'd0, if_kill}, 32'd0);
        chk("rst_fetch_busy", {31'd0, fetch_busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        m_pc = BOOT_PC; m_boot = 1; m_pend = 0; m_ptgt = '0;
    endtask

    // Monitor: per-cycle outputs plus an address check on every accepted fetch.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("inst_req", {31'd0, inst_req}, {31'd0, e.req});
                chk("inst_addr", inst_addr, e.addr);
                chk("if_kill", {31'd0, if_kill}, {31'd0, e.kill});
                chk("fetch_busy", {31'd0, fetch_busy}, {31'd0, e.busy});
            end
            if (resetn && inst_req && inst_addr_ok) begin
                if (fetch_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL fetch_unexpected: got accept of %h expected none", inst_addr);
                end else begin
                    chk("fetch_addr", inst_addr, fetch_q.pop_front());
                end
            end
        end
    end

    initial begin
        resetn = 1'b0;
        idle_inputs();
        m_pc = BOOT_PC; m_boot = 1; m_pend = 0; m_ptgt = '0;
        do_reset();

        // Boot then sequential fetch BFC00000..BFC0000C, pc now BFC00010.
        repeat (5) drive(0, '0, 0, 0, '0, 1);
        // Branch with slot already in pipe: kill and redirect.
        drive(1, 32'hBFC0_0100, 1, 0, '0, 1);
        // Branch whose slot is being accepted this cycle.
        drive(1, 32'hBFC0_0200, 0, 0, '0, 1);
        // Slot not yet accepted: hold in WAIT_DS for three cycles.
        drive(1, 32'hBFC0_0300, 0, 0, '0, 0);
        drive(0, '0, 0, 0, '0, 0);
        drive(0, '0, 0, 0, '0, 0);
        drive(0, '0, 0, 0, '0, 1);
        drive(0, '0, 0, 0, '0, 1);
        // Exception while waiting drops the held target.
        drive(1, 32'hBFC0_0400, 0, 0, '0, 0);
        drive(0, '0, 0, 0, '0, 0);
        drive(0, '0, 0, 1, 32'hBFC0_0380, 0);
        drive(0, '0, 0, 0, '0, 1);
        drive(0, '0, 0, 0, '0, 1);
        // Exception and branch together: exception wins.
        drive(1, 32'hBFC0_0500, 1, 1, 32'hBFC0_0380, 1);
        drive(0, '0, 0, 0, '0, 1);
        // Branch inside WAIT_DS is ignored.
        drive(1, 32'hBFC0_0600, 0, 0, '0, 0);
        drive(1, 32'hBFC0_0700, 1, 0, '0, 0);
        drive(0, '0, 0, 0, '0, 1);
        drive(0, '0, 0, 0, '0, 1);
        // Wrap at the top of the address space.
        drive(0, '0, 0, 1, 32'hFFFF_FFFC, 1);
        drive(0, '0, 0, 0, '0, 1);
        drive(0, '0, 0, 0, '0, 1);
        // Async reset while waiting discards the held target.
        drive(1, 32'hBFC0_0800, 0, 0, '0, 0);
        drive(0, '0, 0, 0, '0, 0);
        do_reset();
        drive(0, '0, 0, 0, '0, 1);
        drive(0, '0, 0, 0, '0, 1);
        drive(0, '0, 0, 0, '0, 1);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] t, et;
            t  = {$urandom} & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            et = {$urandom} & 32'hFFFF_FFFC;
            if (i == 200) do_reset();
            drive($urandom_range(0, 99) < 20, t, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 4, et, $urandom_range(0, 99) < 70);
        end

        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        #3;
        chk("drain_cycle_queue", cyc_q.size(), 32'd0);
        chk("drain_fetch_queue", fetch_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
